// File: rtl/ecc_apb_pkg.sv
// Shared register map, operation/width codes and FSM states for the ECC APB initiator.
package ecc_apb_pkg;

    localparam logic [3:0] CTRL_OFF     = 4'd0;
    localparam logic [3:0] DATA_IN_OFF  = 4'd4;
    localparam logic [3:0] CW_WIDTH_OFF = 4'd8;
    localparam logic [3:0] NOISE_OFF    = 4'd12;

    typedef enum logic [1:0] {
        OP_ENCODE = 2'd0,
        OP_DECODE = 2'd1,
        OP_FULL   = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2
    } width_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_DONE,
        ST_RESP
    } state_e;

    // CTRL goes last because writing it kicks off the ECC operation.
    function automatic logic [3:0] reg_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_offset = DATA_IN_OFF;
            2'd1:    reg_offset = CW_WIDTH_OFF;
            2'd2:    reg_offset = NOISE_OFF;
            default: reg_offset = CTRL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/apb_write_xfer.sv
// One two-phase APB write (SETUP then ACCESS, no PREADY): 2 cycles after start.
// start during the ACCESS cycle chains the next write with no idle gap; start during SETUP is ignored.
module apb_write_xfer #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              psel,
    output logic              penable,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else if (start) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = addr;
            pwdata_d  = wdata;
        end else begin
            // Address and data are left as they were so the bus does not toggle when idle.
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign busy    = psel_q;
    assign done    = psel_q & penable_q;

endmodule

// File: rtl/ecc_apb_initiator.sv
// Programs DATA_IN, CODEWORD_WIDTH, NOISE then CTRL over APB (8 cycles), waits for operation_done or timeout,
// and holds the response on rsp_valid until rsp_ready; no new command is taken until then.
module ecc_apb_initiator
    import ecc_apb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int BASE_ADDR       = 0,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PWRITE,
    output logic                       PSEL,
    output logic                       PENABLE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_num_errors,
    output logic                       rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EXT_W = (DATA_WIDTH > AMBA_WORD) ? DATA_WIDTH : AMBA_WORD;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]              width_q, width_d;
    logic [DATA_WIDTH-1:0]   noise_q, noise_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_nerr_q, rsp_nerr_d;
    logic                    rsp_tmo_q, rsp_tmo_d;

    logic                       xfer_start;
    logic [1:0]                 xfer_idx;
    logic [DATA_WIDTH-1:0]      xfer_val;
    logic [EXT_W-1:0]           xfer_ext;
    logic [AMBA_ADDR_WIDTH-1:0] xfer_addr;
    logic [AMBA_WORD-1:0]       xfer_wdata;
    logic                       xfer_busy;
    logic                       xfer_done;

    // A transfer is launched one cycle before its SETUP, so the register it targets
    // is idx 0 from IDLE (straight from the command inputs) or idx+1 from ACCESS.
    always_comb begin
        xfer_idx = (state_q == ST_IDLE) ? 2'd0 : idx_q + 2'd1;
        xfer_val = '0;
        case (xfer_idx)
            2'd0:    xfer_val = (state_q == ST_IDLE) ? cmd_data : data_q;
            2'd1:    xfer_val = DATA_WIDTH'(width_q);
            2'd2:    xfer_val = noise_q;
            default: xfer_val = DATA_WIDTH'(op_q);
        endcase
        xfer_ext   = EXT_W'(xfer_val);
        xfer_wdata = xfer_ext[AMBA_WORD-1:0];
        xfer_addr  = AMBA_ADDR_WIDTH'(BASE_ADDR) + AMBA_ADDR_WIDTH'(reg_offset(xfer_idx));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        data_d     = data_q;
        width_d    = width_q;
        noise_d    = noise_q;
        rsp_data_d = rsp_data_q;
        rsp_nerr_d = rsp_nerr_q;
        rsp_tmo_d  = rsp_tmo_q;
        xfer_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    data_d     = cmd_data;
                    width_d    = cmd_width;
                    noise_d    = cmd_noise;
                    idx_d      = 2'd0;
                    xfer_start = 1'b1;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (xfer_done) begin
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        xfer_start = 1'b1;
                        state_d    = ST_SETUP;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                // Done on the final allowed cycle still counts as success.
                if (operation_done) begin
                    rsp_data_d = data_out;
                    rsp_nerr_d = num_of_errors;
                    rsp_tmo_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_nerr_d = '0;
                    rsp_tmo_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            data_q     <= '0;
            width_q    <= '0;
            noise_q    <= '0;
            rsp_data_q <= '0;
            rsp_nerr_q <= '0;
            rsp_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            data_q     <= data_d;
            width_q    <= width_d;
            noise_q    <= noise_d;
            rsp_data_q <= rsp_data_d;
            rsp_nerr_q <= rsp_nerr_d;
            rsp_tmo_q  <= rsp_tmo_d;
        end
    end

    apb_write_xfer #(
        .ADDR_W (AMBA_ADDR_WIDTH),
        .DATA_W (AMBA_WORD)
    ) u_xfer (
        .clk     (clk),
        .rst     (rst),
        .start   (xfer_start),
        .addr    (xfer_addr),
        .wdata   (xfer_wdata),
        .busy    (xfer_busy),
        .done    (xfer_done),
        .psel    (PSEL),
        .penable (PENABLE),
        .paddr   (PADDR),
        .pwdata  (PWDATA)
    );

    // State resets to IDLE, so readiness must be masked while reset is held.
    assign cmd_ready      = (state_q == ST_IDLE) & ~rst;
    assign PWRITE         = xfer_busy;
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_data       = rsp_data_q;
    assign rsp_num_errors = rsp_nerr_q;
    assign rsp_timeout    = rsp_tmo_q;

endmodule

// File: tb/tb_ecc_apb_initiator.sv
// Randomised and directed bench for ecc_apb_initiator against a cycle-timeline reference model.
module tb_ecc_apb_initiator;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_width;
    logic [31:0] cmd_noise;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_num_errors;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ecc_apb_initiator #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .BASE_ADDR(0), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_width(cmd_width), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_num_errors(rsp_num_errors), .rsp_timeout(rsp_timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command accepted at edge 0 owns cycles 1..8 for the four writes,
    // cycles 9..8+T are the done window, and the response then waits for rsp_ready.
    bit          m_busy, m_pend, m_tmo;
    int          m_k;
    logic [19:0] m_addr [4];
    logic [31:0] m_wd   [4];
    logic [19:0] m_haddr;
    logic [31:0] m_hwd;
    logic [31:0] m_rdata;
    logic [1:0]  m_rnerr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_pend <= 0; m_tmo <= 0; m_k <= 0;
            m_haddr <= '0; m_hwd <= '0; m_rdata <= '0; m_rnerr <= '0;
        end else begin
            if (m_busy && !m_pend && m_k >= 1 && m_k <= 8) begin
                m_haddr <= m_addr[(m_k - 1) / 2];
                m_hwd   <= m_wd[(m_k - 1) / 2];
            end
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy <= 1; m_k <= 1;
                    m_addr[0] <= 20'h4; m_wd[0] <= cmd_data;
                    m_addr[1] <= 20'h8; m_wd[1] <= {30'd0, cmd_width};
                    m_addr[2] <= 20'hC; m_wd[2] <= cmd_noise;
                    m_addr[3] <= 20'h0; m_wd[3] <= {30'd0, cmd_op};
                end
            end else if (m_pend) begin
                if (rsp_ready) begin m_busy <= 0; m_pend <= 0; end
            end else begin
                if (m_k >= 9 && operation_done) begin
                    m_pend <= 1; m_rdata <= data_out; m_rnerr <= num_of_errors; m_tmo <= 0;
                end else if (m_k == 8 + T) begin
                    m_pend <= 1; m_rdata <= '0; m_rnerr <= '0; m_tmo <= 1;
                end
                m_k <= m_k + 1;
            end
        end
    end

    logic        exp_apb;
    int          exp_i;
    assign exp_apb = m_busy && !m_pend && (m_k >= 1) && (m_k <= 8);
    assign exp_i   = exp_apb ? (m_k - 1) / 2 : 0;

    logic prev_setup = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_pend);
            chk("psel", PSEL, exp_apb);
            chk("penable", PENABLE, exp_apb && (m_k % 2 == 0));
            chk("pwrite", PWRITE, exp_apb);
            chk("paddr", PADDR, exp_apb ? m_addr[exp_i] : m_haddr);
            chk("pwdata", PWDATA, exp_apb ? m_wd[exp_i] : m_hwd);
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_num_errors", rsp_num_errors, m_rnerr);
            if (m_pend) chk("rsp_timeout", rsp_timeout, m_tmo);
            if (PENABLE) chk("penable_after_setup", prev_setup, 1'b1);
            prev_setup <= PSEL && !PENABLE;
        end
    end

    logic [19:0] log_a[$];
    logic [31:0] log_d[$];
    always @(posedge clk) begin
        if (!rst && PSEL && PENABLE) begin
            log_a.push_back(PADDR);
            log_d.push_back(PWDATA);
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] dat, input logic [1:0] w,
                           input logic [31:0] nz, input int d, input logic [31:0] dout,
                           input logic [1:0] nerr, input bit stale, input int hold, input bit keep_valid,
                           output int acc_wait, output int rsp_cyc, output logic [31:0] r_data,
                           output logic [1:0] r_nerr, output logic r_tmo);
        int n, h;
        bit fin;
        cmd_op = op; cmd_data = dat; cmd_width = w; cmd_noise = nz; cmd_valid = 1'b1;
        acc_wait = 0; rsp_cyc = 0; r_data = '0; r_nerr = '0; r_tmo = 1'b0;
        @(negedge clk);
        while (!cmd_ready && acc_wait < 100) begin
            acc_wait++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            chk("cmd_accept_bound", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #2;
        cmd_valid = keep_valid;
        cmd_data = $urandom; cmd_noise = $urandom;
        cmd_op = 2'($urandom); cmd_width = 2'($urandom);
        n = 1; h = 0; fin = 0;
        while (!fin && n < 300) begin
            operation_done = (n == 8 + d) || (stale && n <= 8);
            data_out       = (n == 8 + d) ? dout : (stale ? ~dout : $urandom);
            num_of_errors  = (n == 8 + d) ? nerr : 2'($urandom);
            if (rsp_valid) begin
                rsp_ready = (h >= hold);
                h++;
            end else begin
                rsp_ready = 1'($urandom);
            end
            @(negedge clk);
            if (rsp_valid && rsp_cyc == 0) begin
                rsp_cyc = n; r_data = rsp_data; r_nerr = rsp_num_errors; r_tmo = rsp_timeout;
            end
            fin = rsp_valid && rsp_ready;
            @(posedge clk); #2;
            n++;
        end
        if (!fin) chk("rsp_handshake_bound", 64'd0, 64'd1);
        cmd_valid = 1'b0; rsp_ready = 1'b0; operation_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw, rc;
        logic [31:0] rd, dv;
        logic [1:0]  rn;
        logic        rt;
        rst = 0; cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_width = 0; cmd_noise = 0;
        operation_done = 0; data_out = 0; num_of_errors = 0; rsp_ready = 0;
        #1 rst = 1;
        @(posedge clk); #2;
        chk("reset_psel", PSEL, 0);
        chk("reset_penable", PENABLE, 0);
        chk("reset_pwrite", PWRITE, 0);
        chk("reset_paddr", PADDR, 0);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("cmd_ready_after_release", cmd_ready, 1);
        @(posedge clk); #2;

        // Encode, no errors
        log_a.delete(); log_d.delete();
        run_cmd(2'd0, 32'hA5, 2'd0, 32'h0, 3, 32'h5A, 2'd0, 0, 0, 0, aw, rc, rd, rn, rt);
        chk("enc_log_size", log_a.size(), 4);
        chk("enc_w0_addr", log_a[0], 20'h4); chk("enc_w0_data", log_d[0], 32'hA5);
        chk("enc_w1_addr", log_a[1], 20'h8); chk("enc_w1_data", log_d[1], 32'h0);
        chk("enc_w2_addr", log_a[2], 20'hC); chk("enc_w2_data", log_d[2], 32'h0);
        chk("enc_w3_addr", log_a[3], 20'h0); chk("enc_w3_data", log_d[3], 32'h0);
        chk("enc_rsp_cycle", rc, 12);
        chk("enc_rsp_data", rd, 32'h5A); chk("enc_rsp_nerr", rn, 0); chk("enc_rsp_tmo", rt, 0);

        // Decode, one error
        log_a.delete(); log_d.delete();
        run_cmd(2'd1, 32'h1234, 2'd1, 32'h10, 3, 32'h34, 2'd1, 0, 0, 0, aw, rc, rd, rn, rt);
        chk("dec_ctrl_addr", log_a[3], 20'h0); chk("dec_ctrl_data", log_d[3], 32'h1);
        chk("dec_cw_data", log_d[1], 32'h1); chk("dec_noise_data", log_d[2], 32'h10);
        chk("dec_rsp_data", rd, 32'h34); chk("dec_rsp_nerr", rn, 1);

        // Timeout: done never arrives
        run_cmd(2'd2, 32'hDEAD, 2'd2, 32'h3, 1000, 32'h0, 2'd0, 0, 0, 0, aw, rc, rd, rn, rt);
        chk("tmo_rsp_cycle", rc, 9 + T); chk("tmo_flag", rt, 1); chk("tmo_data", rd, 0);

        // Done on the last window cycle wins; one cycle later is a timeout
        run_cmd(2'd0, 32'h77, 2'd0, 32'h0, T, 32'hBEEF, 2'd2, 0, 0, 0, aw, rc, rd, rn, rt);
        chk("limit_rsp_cycle", rc, 9 + T); chk("limit_tmo", rt, 0); chk("limit_data", rd, 32'hBEEF);
        run_cmd(2'd0, 32'h77, 2'd0, 32'h0, T + 1, 32'hBEEF, 2'd2, 0, 0, 0, aw, rc, rd, rn, rt);
        chk("late_rsp_cycle", rc, 9 + T); chk("late_tmo", rt, 1); chk("late_data", rd, 0);

        // Stale done during programming
        run_cmd(2'd2, 32'h55, 2'd2, 32'h1, 5, 32'hCAFE0001, 2'd2, 1, 0, 0, aw, rc, rd, rn, rt);
        chk("stale_rsp_cycle", rc, 14); chk("stale_data", rd, 32'hCAFE0001); chk("stale_nerr", rn, 2);

        // Back-pressure with cmd_valid held, then immediate re-accept
        run_cmd(2'd1, 32'h99, 2'd1, 32'h2, 2, 32'h1111, 2'd1, 0, 10, 1, aw, rc, rd, rn, rt);
        run_cmd(2'd0, 32'hAB, 2'd0, 32'h0, 2, 32'h2222, 2'd0, 0, 0, 0, aw, rc, rd, rn, rt);
        chk("bp_reaccept_wait", aw, 0); chk("bp_next_data", rd, 32'h2222);

        // Randomised commands
        for (int i = 0; i < 25; i++) begin
            dv = $urandom;
            run_cmd(2'($urandom), $urandom, 2'($urandom_range(0, 2)), $urandom,
                    $urandom_range(1, T + 6), dv, 2'($urandom), 1'($urandom), $urandom_range(0, 3),
                    0, aw, rc, rd, rn, rt);
        end

        // Reset during the NOISE ACCESS cycle
        log_a.delete(); log_d.delete();
        cmd_op = 2'd2; cmd_data = 32'h3C; cmd_width = 2'd0; cmd_noise = 32'h5; cmd_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_before", cmd_ready, 1);
        @(posedge clk); #2 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_rst_noise_paddr", PADDR, 20'hC);
        chk("mid_rst_noise_penable", PENABLE, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_psel", PSEL, 0); chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0); chk("mid_rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_after", cmd_ready, 1);
        repeat (15) @(posedge clk);
        #2;
        chk("mid_rst_no_more_writes", log_a.size(), 2);

        // Recovery command after the abort
        run_cmd(2'd1, 32'h4242, 2'd2, 32'h8, 4, 32'h4240, 2'd1, 0, 1, 0, aw, rc, rd, rn, rt);
        chk("recover_data", rd, 32'h4240); chk("recover_rsp_cycle", rc, 13);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
